lcd_bus_arbiter: RTL and testbench

- Shares one HD44780-style 8-bit character LCD bus between N_REQ message generators, such as menu and status message FSMs.
- Each generator opens a session, then issues data writes (RS=1) or command writes (RS=0), one byte at a time.
- The block grants sessions round-robin and turns each accepted byte into a timed bus cycle: RS/DB setup, E pulse, hold, then an execution wait.
- It sits between the message FSMs and the LCD pins.

---
 rtl/lcd_bus_arbiter_if.sv | 27 ++
 rtl/lcd_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side handshake and LCD pin bundle for lcd_bus_arbiter.
// The arbiter connects through the slave modport; requesters and the LCD use master.
interface lcd_bus_arbiter_if #(
  parameter int N_REQ = 2
) ();
  logic [N_REQ-1:0]   sess_req;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   op_valid;
  logic [N_REQ-1:0]   op_rs;
  logic [8*N_REQ-1:0] op_data;
  logic [N_REQ-1:0]   op_ack;
  logic               busy;
  logic               lcd_e;
  logic               lcd_rs;
  logic               lcd_rw;
  logic [7:0]         lcd_db;

  modport slave (
    input  sess_req, op_valid, op_rs, op_data,
    output grant, op_ack, busy, lcd_e, lcd_rs, lcd_rw, lcd_db
  );

  modport master (
    output sess_req, op_valid, op_rs, op_data,
    input  grant, op_ack, busy, lcd_e, lcd_rs, lcd_rw, lcd_db
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Round-robin session arbiter for a shared HD44780-style 8-bit LCD bus.
// Each accepted byte becomes a timed write: RS/DB setup, E pulse, hold,
// then an execution wait (long for clear/home commands).
module lcd_bus_arbiter #(
  parameter int N_REQ       = 2,
  parameter int T_SETUP     = 2,
  parameter int T_EHI       = 10,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 800,
  parameter int T_EXEC_LONG = 33000,
  parameter int CW          = 16
) (
  input logic              clk,
  input logic              rst,
  lcd_bus_arbiter_if.slave bus
);

  localparam int          OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NR = N_REQ;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OP,
    SETUP,
    E_HI,
    HOLD,
    EXEC
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;

  logic             owner_req;
  logic             owner_valid;
  logic             owner_rs;
  logic [7:0]       owner_byte;
  logic             long_wait;
  logic             rr_found;
  logic [OW-1:0]    rr_idx;
  logic [OW-1:0]    cand;

  // Select the current owner's request lines and byte.
  always_comb begin
    owner_req   = bus.sess_req[owner_q];
    owner_valid = bus.op_valid[owner_q];
    owner_rs    = bus.op_rs[owner_q];
    owner_byte  = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (owner_q == OW'(i)) owner_byte = bus.op_data[8*i +: 8];
    end
  end

  // Round-robin pick: first active session request after the last owner.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = owner_q;
    cand     = owner_q;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = OW'((32'(owner_q) + k) % NR);
      if (!rr_found && bus.sess_req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
  always_comb begin
    long_wait = !rs_q && (db_q[7:2] == '0) && (db_q != '0);
  end

  // State and datapath registers; reset drops E immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      owner_q <= OW'(N_REQ - 1);
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
    end
  end

  // Next-state logic: arbitration, byte latch and bus-cycle timing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    owner_d = owner_q;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d         = '0;
          grant_d[rr_idx] = 1'b1;
          owner_d         = rr_idx;
          state_d         = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (!owner_req) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (owner_valid) begin
          rs_d    = owner_rs;
          db_d    = owner_byte;
          cnt_d   = CW'(T_SETUP - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          e_d     = 1'b1;
          cnt_d   = CW'(T_EHI - 1);
          state_d = E_HI;
        end
      end
      E_HI: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          e_d     = 1'b0;
          cnt_d   = CW'(T_HOLD - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d   = long_wait ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (owner_req) begin
          state_d = WAIT_OP;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        e_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: ack is combinational so it pulses in the cycle the byte is latched.
  always_comb begin
    bus.op_ack = '0;
    if (state_q == WAIT_OP && owner_req && owner_valid) bus.op_ack = grant_q;
    bus.grant  = grant_q;
    bus.busy   = (state_q != IDLE);
    bus.lcd_e  = e_q;
    bus.lcd_rs = rs_q;
    bus.lcd_rw = 1'b0;
    bus.lcd_db = db_q;
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with default timing parameters.
module tb_lcd_bus_arbiter;

  logic clk;
  logic rst;

  lcd_bus_arbiter_if #(.N_REQ(2)) bus ();

  lcd_bus_arbiter #(
    .N_REQ(2),
    .T_SETUP(2),
    .T_EHI(10),
    .T_HOLD(2),
    .T_EXEC(800),
    .T_EXEC_LONG(33000),
    .CW(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int e_rises  = 0;
  logic e_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ack pulses and E rising edges independently of the stimulus.
  always @(posedge clk) begin
    if (bus.op_ack[0] === 1'b1) ack0_cnt++;
    if (bus.op_ack[1] === 1'b1) ack1_cnt++;
    if (bus.lcd_e === 1'b1 && e_prev !== 1'b1) e_rises++;
    e_prev = bus.lcd_e;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offer one byte, wait for its ack, then time the setup and E-high phases.
  // Returns at the first hold-cycle negedge.
  task automatic write_byte(input int req, input logic rs, input logic [7:0] data,
                            input bit drop, input int exp_w, input string tag);
    int w;
    int ns;
    int ne;
    bus.op_rs[req]           = rs;
    bus.op_data[8*req +: 8]  = data;
    bus.op_valid[req]        = 1'b1;
    #1;
    w = 0;
    while (bus.op_ack[req] !== 1'b1 && w < 40000) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ack wait"}, w, exp_w);
    @(posedge clk);
    #1 bus.op_valid[req] = 1'b0;
    ns = 0;
    @(negedge clk);
    while (bus.lcd_e === 1'b0 && ns < 20) begin
      if (ns == 0) begin
        check({tag, " rs setup"}, bus.lcd_rs, rs);
        check({tag, " db setup"}, bus.lcd_db, data);
      end
      ns++;
      @(negedge clk);
    end
    check({tag, " setup cycles"}, ns, 2);
    ne = 0;
    while (bus.lcd_e === 1'b1 && ne < 20) begin
      if (drop && ne == 0) bus.sess_req[req] = 1'b0;
      ne++;
      @(negedge clk);
    end
    check({tag, " e high cycles"}, ne, 10);
    check({tag, " db hold"}, bus.lcd_db, data);
  endtask

  task automatic wait_grant_not(input logic [1:0] g, output int w);
    w = 0;
    while (bus.grant === g && w < 40000) begin
      @(negedge clk);
      w++;
    end
  endtask

  initial begin
    int w;
    int a0;
    int a1;
    int er;
    logic [7:0] str [12];
    str = '{8'h50, 8'h72, 8'h65, 8'h73, 8'h69, 8'h6F,
            8'h6E, 8'h65, 8'h20, 8'h28, 8'h30, 8'h29};

    rst          = 1'b0;
    bus.sess_req = '0;
    bus.op_valid = '0;
    bus.op_rs    = '0;
    bus.op_data  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst grant", bus.grant, 0);
    check("rst ack", bus.op_ack, 0);
    check("rst busy", bus.busy, 0);
    check("rst e", bus.lcd_e, 0);
    check("rst rs", bus.lcd_rs, 0);
    check("rst rw", bus.lcd_rw, 0);
    check("rst db", bus.lcd_db, 0);

    // Single requester: data, clear, DDRAM address, data.
    rst = 1'b1;
    bus.sess_req = 2'b01;
    a0 = ack0_cnt;
    er = e_rises;
    write_byte(0, 1'b1, 8'h43, 1'b0, 1, "C");
    check("C ack once", ack0_cnt - a0, 1);
    write_byte(0, 1'b0, 8'h01, 1'b0, 802, "clear");
    write_byte(0, 1'b0, 8'h80, 1'b0, 33002, "ddram");
    write_byte(0, 1'b1, 8'h2E, 1'b0, 802, "dot");
    bus.sess_req[0] = 1'b0;
    wait_grant_not(2'b01, w);
    check("end sess cycles", w, 802);
    check("end sess busy", bus.busy, 0);
    check("idle db held", bus.lcd_db, 8'h2E);
    check("idle rs held", bus.lcd_rs, 1);
    check("A ack count", ack0_cnt - a0, 4);
    check("A e count", e_rises - er, 4);

    // Session dropped while E is high.
    bus.sess_req = 2'b01;
    write_byte(0, 1'b1, 8'h41, 1'b1, 1, "dropE");
    wait_grant_not(2'b01, w);
    check("dropE exec cycles", w, 802);
    check("dropE grant", bus.grant, 0);

    // Two requesters from reset; requester 1 holds a byte throughout.
    rst                = 1'b0;
    bus.sess_req       = 2'b11;
    bus.op_valid       = 2'b10;
    bus.op_rs[1]       = 1'b1;
    bus.op_data[15:8]  = 8'h55;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rr first grant", bus.grant, 2'b01);
    check("rr non-owner ack", bus.op_ack, 0);
    a1 = ack1_cnt;
    write_byte(0, 1'b1, 8'h31, 1'b0, 0, "rr0");
    bus.sess_req[0] = 1'b0;
    wait_grant_not(2'b01, w);
    check("rr0 exec cycles", w, 802);
    check("rr0 released", bus.grant, 0);
    check("rr1 no early ack", ack1_cnt - a1, 0);
    @(negedge clk);
    check("rr second grant", bus.grant, 2'b10);
    check("rr1 ack", bus.op_ack, 2'b10);
    write_byte(1, 1'b1, 8'h55, 1'b0, 0, "rr1");
    bus.sess_req[1] = 1'b0;
    wait_grant_not(2'b10, w);
    check("rr1 exec cycles", w, 802);
    bus.sess_req = 2'b11;
    @(negedge clk);
    check("rr third grant", bus.grant, 2'b01);
    bus.sess_req = 2'b01;

    // Reset during E high.
    bus.op_rs[0]      = 1'b0;
    bus.op_data[7:0]  = 8'h99;
    bus.op_valid[0]   = 1'b1;
    #1;
    w = 0;
    while (bus.op_ack[0] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("abort ack wait", w, 0);
    @(posedge clk);
    #1 bus.op_valid[0] = 1'b0;
    w = 0;
    while (bus.lcd_e !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("abort e rise", bus.lcd_e, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    a0 = ack0_cnt;
    #2 rst = 1'b0;
    #1;
    check("abort e async", bus.lcd_e, 0);
    check("abort grant", bus.grant, 0);
    check("abort busy", bus.busy, 0);
    check("abort db", bus.lcd_db, 0);
    @(negedge clk);
    rst = 1'b1;
    check("abort idle", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort regrant", bus.grant, 2'b01);
    check("abort no ack", ack0_cnt - a0, 0);
    check("abort e low", bus.lcd_e, 0);
    bus.sess_req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("abort release", bus.grant, 0);

    // Message string "Presione (0)".
    bus.sess_req = 2'b01;
    a0 = ack0_cnt;
    er = e_rises;
    for (int i = 0; i < 12; i++) begin
      write_byte(0, 1'b1, str[i], 1'b0, (i == 0) ? 1 : 802, $sformatf("str%0d", i));
    end
    bus.sess_req = 2'b00;
    wait_grant_not(2'b01, w);
    check("str exec cycles", w, 802);
    check("str ack count", ack0_cnt - a0, 12);
    check("str e count", e_rises - er, 12);
    check("str rw", bus.lcd_rw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
